// File: rtl/uart_program_loader.sv
// ============================================================================
//  Module   : uart_program_loader
//  Purpose  : Decodes LOAD/RUN byte commands from the UART receiver and writes
//             little-endian 32-bit words sequentially into instruction memory.
//             Optional idle-byte timeout enabled by defining LOADER_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_program_loader #(
    parameter int NB_DATA        = 8,
    parameter int NB_WORD        = 32,
    parameter int NB_ADDR        = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [NB_DATA-1:0] din,
    output logic               mem_wr_en,
    output logic [NB_ADDR-1:0] mem_addr,
    output logic [NB_WORD-1:0] mem_wr_data,
    output logic               busy,
    output logic               load_done,
    output logic               run_start,
    output logic               err
);

    localparam int                 c_lanes    = NB_WORD / NB_DATA;
    localparam int                 c_idx_w    = (c_lanes > 1) ? $clog2(c_lanes) : 1;
    localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(c_lanes - 1);
    localparam logic [NB_DATA-1:0] c_cmd_load = NB_DATA'(1);
    localparam logic [NB_DATA-1:0] c_cmd_run  = NB_DATA'(2);

    generate
        if (NB_WORD != 4 * NB_DATA || TIMEOUT_CYCLES < 2) begin : g_bad_params
            $error("uart_program_loader: NB_WORD must be 4*NB_DATA and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GET_COUNT = 3'd1,
        S_GET_BYTE  = 3'd2,
        S_WRITE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t               state_q;
    logic [NB_DATA-1:0]   count_q;
    logic [NB_DATA-1:0]   word_cnt_q;
    logic [NB_DATA:0]     word_cnt_d;
    logic [c_idx_w-1:0]   idx_q;
    logic [NB_WORD-1:0]   word_q;
    logic                 mem_wr_en_q;
    logic [NB_ADDR-1:0]   mem_addr_q;
    logic [NB_WORD-1:0]   mem_wr_data_q;
    logic                 busy_q;
    logic                 load_done_q;
    logic                 run_start_q;
    logic                 err_q;
    logic                 timeout;

    assign word_cnt_d = {1'b0, word_cnt_q} + 1'b1;

`ifdef LOADER_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES);

    logic [c_tmo_w-1:0] tmo_cnt_q;
    logic               waiting;

    assign waiting = (state_q == S_GET_COUNT) || (state_q == S_GET_BYTE);
    assign timeout = waiting && (tmo_cnt_q == c_tmo_w'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else if (rx_done_tick || !waiting || timeout) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            word_cnt_q    <= '0;
            idx_q         <= '0;
            word_q        <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            busy_q        <= 1'b0;
            load_done_q   <= 1'b0;
            run_start_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            mem_wr_en_q <= 1'b0;
            load_done_q <= 1'b0;
            run_start_q <= 1'b0;
            err_q       <= 1'b0;

            // Address advances in the cycle after the write strobe it accompanied.
            if (mem_wr_en_q) begin
                mem_addr_q <= mem_addr_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rx_done_tick) begin
                        if (din == c_cmd_load) begin
                            state_q    <= S_GET_COUNT;
                            busy_q     <= 1'b1;
                            mem_addr_q <= '0;
                        end else if (din == c_cmd_run) begin
                            run_start_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                S_GET_COUNT: begin
                    if (rx_done_tick) begin
                        if (din == '0) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            count_q    <= din;
                            idx_q      <= '0;
                            word_cnt_q <= '0;
                            state_q    <= S_GET_BYTE;
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_GET_BYTE: begin
                    if (rx_done_tick) begin
                        word_q[idx_q*NB_DATA +: NB_DATA] <= din;
                        if (idx_q == c_last_idx) begin
                            state_q <= S_WRITE;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (timeout) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                S_WRITE: begin
                    mem_wr_en_q   <= 1'b1;
                    mem_wr_data_q <= word_q;
                    word_cnt_q    <= word_cnt_d[NB_DATA-1:0];
                    if (word_cnt_d == {1'b0, count_q}) begin
                        state_q <= S_DONE;
                    end else begin
                        idx_q   <= '0;
                        state_q <= S_GET_BYTE;
                    end
                end

                S_DONE: begin
                    load_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_wr_en   = mem_wr_en_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wr_data = mem_wr_data_q;
    assign busy        = busy_q;
    assign load_done   = load_done_q;
    assign run_start   = run_start_q;
    assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_program_loader.sv
// ============================================================================
//  Module   : tb_uart_program_loader
//  Purpose  : Scoreboard bench for uart_program_loader; expected writes and
//             pulses are queued by the stimulus and popped by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_program_loader;

    localparam int NB_DATA = 8;
    localparam int NB_WORD = 32;
    localparam int NB_ADDR = 8;
    localparam int TMO     = 1000;
    localparam int GAP     = 8;

    logic               clock        = 1'b0;
    logic               reset        = 1'b0;
    logic               rx_done_tick = 1'b0;
    logic [NB_DATA-1:0] din          = '0;
    logic               mem_wr_en;
    logic [NB_ADDR-1:0] mem_addr;
    logic [NB_WORD-1:0] mem_wr_data;
    logic               busy;
    logic               load_done;
    logic               run_start;
    logic               err;

    always #10 clock = ~clock;

    uart_program_loader #(
        .NB_DATA       (NB_DATA),
        .NB_WORD       (NB_WORD),
        .NB_ADDR       (NB_ADDR),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .rx_done_tick(rx_done_tick),
        .din         (din),
        .mem_wr_en   (mem_wr_en),
        .mem_addr    (mem_addr),
        .mem_wr_data (mem_wr_data),
        .busy        (busy),
        .load_done   (load_done),
        .run_start   (run_start),
        .err         (err)
    );

    typedef struct packed {
        logic [NB_ADDR-1:0] addr;
        logic [NB_WORD-1:0] data;
    } wr_t;

    localparam int P_DONE = 1;
    localparam int P_RUN  = 2;
    localparam int P_ERR  = 3;

    wr_t exp_wr[$];
    int  exp_pulse[$];
    int  n_pass       = 0;
    int  n_total      = 0;
    int  cyc          = 0;
    int  last_tick    = 0;
    int  err_cyc      = -1;
    logic prev_wr     = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic pop_pulse(input int code);
        if (exp_pulse.size() == 0) begin
            chk("pulse_queue_nonempty", 64'(exp_pulse.size()), 64'd1);
        end else begin
            chk("pulse_kind", 64'(code), 64'(exp_pulse.pop_front()));
        end
    endtask

    // Monitor: compares every DUT output event against the scoreboard queues.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_wr_en) begin
                if (exp_wr.size() == 0) begin
                    chk("write_queue_nonempty", 64'(exp_wr.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(mem_addr), 64'(e.addr));
                    chk("wr_data", 64'(mem_wr_data), 64'(e.data));
                end
            end
            if (load_done) begin
                pop_pulse(P_DONE);
                chk("done_follows_write", 64'(prev_wr), 64'd1);
            end
            if (run_start) pop_pulse(P_RUN);
            if (err) begin
                pop_pulse(P_ERR);
                err_cyc = cyc;
            end
            prev_wr = mem_wr_en;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clock);
        rx_done_tick = 1'b1;
        din          = b;
        @(negedge clock);
        rx_done_tick = 1'b0;
        last_tick    = cyc;
        repeat (GAP) @(negedge clock);
    endtask

    task automatic send_bytes(input logic [7:0] b [], input int n);
        for (int i = 0; i < n; i++) send_byte(b[i]);
    endtask

    task automatic push_wr(input logic [NB_ADDR-1:0] a, input logic [NB_WORD-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_wr.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_en"},   64'(mem_wr_en),   64'd0);
        chk({tag, "_addr"},    64'(mem_addr),    64'd0);
        chk({tag, "_data"},    64'(mem_wr_data), 64'd0);
        chk({tag, "_busy"},    64'(busy),        64'd0);
        chk({tag, "_done"},    64'(load_done),   64'd0);
        chk({tag, "_run"},     64'(run_start),   64'd0);
        chk({tag, "_err"},     64'(err),         64'd0);
    endtask

    initial begin
        logic [7:0] seq [];

        repeat (3) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // Single-word load
        push_wr(8'h00, 32'h1234_5678);
        exp_pulse.push_back(P_DONE);
        send_byte(8'h01);
        chk("busy_after_load_cmd", 64'(busy), 64'd1);
        seq = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
        send_bytes(seq, 5);
        chk("busy_after_load", 64'(busy), 64'd0);
        chk("data_held", 64'(mem_wr_data), 64'h1234_5678);

        // Two-word load
        push_wr(8'h00, 32'hDEAD_BEEF);
        push_wr(8'h01, 32'h0102_0304);
        exp_pulse.push_back(P_DONE);
        seq = '{8'h01, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
        send_bytes(seq, 10);
        chk("addr_after_two", 64'(mem_addr), 64'd2);

        // Invalid command byte
        exp_pulse.push_back(P_ERR);
        send_byte(8'h7F);
        chk("busy_after_7f", 64'(busy), 64'd0);

        // Zero count
        exp_pulse.push_back(P_ERR);
        seq = '{8'h01, 8'h00};
        send_bytes(seq, 2);
        chk("busy_after_n0", 64'(busy), 64'd0);

        // RUN leaves the data/address registers untouched
        exp_pulse.push_back(P_RUN);
        send_byte(8'h02);
        chk("run_busy", 64'(busy), 64'd0);
        chk("run_data", 64'(mem_wr_data), 64'h0102_0304);
        chk("run_addr", 64'(mem_addr), 64'd0);

        push_wr(8'h00, 32'h89AB_CDEF);
        exp_pulse.push_back(P_DONE);
        seq = '{8'h01, 8'h01, 8'hEF, 8'hCD, 8'hAB, 8'h89};
        send_bytes(seq, 6);

        // Reset in the middle of a word
        seq = '{8'h01, 8'h01, 8'hAA, 8'hBB};
        send_bytes(seq, 4);
        chk("busy_mid_load", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk_all_zero("midreset");
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        push_wr(8'h00, 32'h4433_2211);
        exp_pulse.push_back(P_DONE);
        seq = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        send_bytes(seq, 6);
        chk("busy_after_reload", 64'(busy), 64'd0);

`ifdef LOADER_TIMEOUT_EN
        exp_pulse.push_back(P_ERR);
        err_cyc = -1;
        seq = '{8'h01, 8'h01, 8'hAA};
        send_bytes(seq, 3);
        repeat (TMO + 100) @(negedge clock);
        chk("timeout_seen", 64'(err_cyc >= 0), 64'd1);
        chk("timeout_window", 64'((err_cyc - last_tick) >= TMO - 5 && (err_cyc - last_tick) <= TMO + 5), 64'd1);
        chk("timeout_busy", 64'(busy), 64'd0);
`endif

        repeat (20) @(negedge clock);
        chk("writes_drained", 64'(exp_wr.size()), 64'd0);
        chk("pulses_drained", 64'(exp_pulse.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
